// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, FSM states and instruction field offsets for the proto-processor
package proc_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd5;
    localparam logic [2:0] OP_LDI  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    // Instruction layout: [7:5] opcode, [4:3] rA, [2:1] rB, [4:0] immediate
    localparam int OPC_LSB   = 5;
    localparam int OPC_W     = 3;
    localparam int RA_LSB    = 3;
    localparam int RB_LSB    = 1;
    localparam int RIDX_W    = 2;
    localparam int IMM_LSB   = 0;
    localparam int IMM_W     = 5;
    localparam int NUM_REGS  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC1,
        ST_EXEC2,
        ST_WB,
        ST_HALTED
    } state_t;

endpackage

// File: rtl/instr_rom.sv
// rtl/instr_rom.sv - program memory, one write port and one registered read port
// Ports: clk; we/waddr/wdata write port; raddr in, rdata out one cycle later.
module instr_rom #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // No reset: program contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fetch_issue.sv
// rtl/fetch_issue.sv - fetch/decode/issue stage with register file, writeback, local jump and halt
// Ports: clk, rst_n (async active-low); start pulse; prog_we/prog_addr/prog_data program load;
//        res_in execute result; instr/regA/regB/main_enable to execute unit; pc, busy, halted status.
// Build option: FETCH_JMP_EN makes opcode 5 a local jump; otherwise it is issued like 1-4.
module fetch_issue
    import proc_pkg::*;
#(
    parameter int DATASIZE   = 8,
    parameter int PROG_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [7:0]                    prog_data,
    input  logic [7:0]                    res_in,
    output logic [7:0]                    instr,
    output logic [DATASIZE-1:0]           regA,
    output logic [DATASIZE-1:0]           regB,
    output logic                          main_enable,
    output logic [$clog2(PROG_DEPTH)-1:0] pc,
    output logic                          busy,
    output logic                          halted
);

    localparam int PCW = $clog2(PROG_DEPTH);

    state_t              state;
    state_t              state_nx;
    logic [7:0]          fetched;
    logic [DATASIZE-1:0] rf [NUM_REGS];
    logic [OPC_W-1:0]    dec_op;
    logic [OPC_W-1:0]    wb_op;
    logic                dec_jmp;
    logic                rom_we;
    logic [DATASIZE-1:0] res_fit;
    logic [PCW-1:0]      jmp_target;
    logic [PCW-1:0]      pc_inc;

    assign dec_op  = fetched[OPC_LSB +: OPC_W];
    assign wb_op   = instr[OPC_LSB +: OPC_W];
    assign res_fit = DATASIZE'(res_in);
    assign rom_we  = prog_we && (state == ST_IDLE || state == ST_HALTED);

`ifdef FETCH_JMP_EN
    assign dec_jmp = (dec_op == OP_JMP);
`else
    assign dec_jmp = 1'b0;
`endif

    assign jmp_target = PCW'({27'd0, fetched[IMM_LSB +: IMM_W]} % 32'(PROG_DEPTH));
    assign pc_inc     = (pc == PCW'(PROG_DEPTH - 1)) ? '0 : pc + 1'b1;

    // Read address is the live pc: the word captured at the end of FETCH is
    // the one DECODE acts on, since pc only moves at DECODE exit.
    instr_rom #(
        .DEPTH (PROG_DEPTH),
        .AW    (PCW)
    ) u_rom (
        .clk   (clk),
        .we    (rom_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (fetched)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        main_enable = 1'b0;
        busy        = 1'b1;
        halted      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = ST_FETCH;
            end
            ST_FETCH: state_nx = ST_DECODE;
            ST_DECODE: begin
                if (dec_op == OP_HALT) state_nx = ST_HALTED;
                else if (dec_jmp)      state_nx = ST_FETCH;
                else                   state_nx = ST_EXEC1;
            end
            ST_EXEC1: begin
                main_enable = 1'b1;
                state_nx    = ST_EXEC2;
            end
            ST_EXEC2: begin
                main_enable = 1'b1;
                state_nx    = ST_WB;
            end
            ST_WB: state_nx = ST_FETCH;
            ST_HALTED: begin
                busy   = 1'b0;
                halted = 1'b1;
                if (start) state_nx = ST_FETCH;
            end
            default: begin
                busy     = 1'b0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    // instr/regA/regB change only at DECODE exit, so they stay stable through
    // EXEC1, EXEC2 and WB as the execute unit requires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            instr <= '0;
            regA  <= '0;
            regB  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (start) pc <= '0;
                end
                ST_DECODE: begin
                    instr <= fetched;
                    regA  <= rf[fetched[RA_LSB +: RIDX_W]];
                    regB  <= rf[fetched[RB_LSB +: RIDX_W]];
                    if (dec_op != OP_HALT) begin
                        pc <= dec_jmp ? jmp_target : pc_inc;
                    end
                end
                ST_WB: begin
                    if (wb_op == OP_ADD) begin
                        rf[instr[RA_LSB +: RIDX_W]] <= res_fit;
                    end else if (wb_op == OP_LDI) begin
                        rf[0] <= res_fit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_issue.sv
// tb/tb_fetch_issue.sv - randomized self-checking bench for fetch_issue against an instruction-level trace model
module tb_fetch_issue;

    localparam int D = 32;
`ifdef FETCH_JMP_EN
    localparam bit JMP_EN = 1'b1;
`else
    localparam bit JMP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       prog_we = 1'b0;
    logic [4:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic [7:0] res_in = '0;
    logic [7:0] instr;
    logic [7:0] regA;
    logic [7:0] regB;
    logic       main_enable;
    logic [4:0] pc;
    logic       busy;
    logic       halted;

    fetch_issue #(.DATASIZE(8), .PROG_DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .res_in      (res_in),
        .instr       (instr),
        .regA        (regA),
        .regB        (regB),
        .main_enable (main_enable),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] instr;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       me;
        logic [4:0] pc;
        logic       busy;
        logic       halted;
        logic [7:0] res;
    } rec_t;

    rec_t       trace[$];
    logic [7:0] forced_res[$];
    logic [7:0] obs_a[$];
    logic [7:0] obs_b[$];
    logic [7:0] m_mem [D];
    logic [7:0] m_r [4];
    logic [7:0] m_i, m_a, m_b;
    int         m_pc;
    bit         m_halt;
    int         me_cnt, busy_cnt;
    bit         saw_wrap;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic me, input logic bsy, input logic hlt, input logic [7:0] res);
        rec_t r;
        r.instr = m_i; r.ra = m_a; r.rb = m_b; r.me = me;
        r.pc = 5'(m_pc); r.busy = bsy; r.halted = hlt; r.res = res;
        trace.push_back(r);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        m_i = '0; m_a = '0; m_b = '0; m_pc = 0; m_halt = 1'b0;
    endfunction

    // Expected per-cycle trace of one program run, instruction by instruction.
    // The run ends at HALT, or at the EXEC1 (or jump DECODE) of the last allowed instruction.
    function automatic void gen(input int max_instr);
        logic [7:0] w;
        logic [2:0] op;
        logic [7:0] res;
        m_pc = 0;
        for (int n = 0; n < max_instr; n++) begin
            w  = m_mem[m_pc];
            op = w[7:5];
            push(1'b0, 1'b1, 1'b0, 8'h00);
            push(1'b0, 1'b1, 1'b0, 8'h00);
            m_i = w; m_a = m_r[w[4:3]]; m_b = m_r[w[2:1]];
            if (op == 3'd7) begin
                push(1'b0, 1'b0, 1'b1, 8'h00);
                return;
            end
            if (op == 3'd5 && JMP_EN) begin
                m_pc = int'(w[4:0]) % D;
                continue;
            end
            m_pc = (m_pc + 1) % D;
            push(1'b1, 1'b1, 1'b0, 8'h00);
            if (n == max_instr - 1) return;
            push(1'b1, 1'b1, 1'b0, 8'h00);
            res = (forced_res.size() != 0) ? forced_res.pop_front() : 8'($urandom);
            push(1'b0, 1'b1, 1'b0, res);
            if (op == 3'd0)      m_r[w[4:3]] = res;
            else if (op == 3'd6) m_r[0] = res;
        end
    endfunction

    task automatic sync_mem();
        for (int a = 0; a < D; a++) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = 5'(a); prog_data = m_mem[a];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic cmp(input int k);
        rec_t r;
        r = trace[k];
        chk("instr", 32'(instr), 32'(r.instr));
        chk("regA", 32'(regA), 32'(r.ra));
        chk("regB", 32'(regB), 32'(r.rb));
        chk("main_enable", 32'(main_enable), 32'(r.me));
        chk("pc", 32'(pc), 32'(r.pc));
        chk("busy", 32'(busy), 32'(r.busy));
        chk("halted", 32'(halted), 32'(r.halted));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_instr"}, 32'(instr), 32'd0);
        chk({tag, "_regA"}, 32'(regA), 32'd0);
        chk({tag, "_regB"}, 32'(regB), 32'd0);
        chk({tag, "_me"}, 32'(main_enable), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    // Single compare loop: every cycle of the run is checked against the trace.
    task automatic run(input int max_instr);
        bit prev31;
        trace.delete(); obs_a.delete(); obs_b.delete();
        me_cnt = 0; busy_cnt = 0; saw_wrap = 1'b0; prev31 = 1'b0;
        push(1'b0, 1'b0, m_halt, 8'h00);
        gen(max_instr);
        for (int k = 0; k < trace.size(); k++) begin
            @(negedge clk);
            cmp(k);
            if (main_enable) begin
                obs_a.push_back(regA); obs_b.push_back(regB); me_cnt++;
            end
            if (busy) busy_cnt++;
            if (prev31 && pc == 5'd0) saw_wrap = 1'b1;
            prev31 = (pc == 5'd31);
            res_in = trace[k].res;
            if (k == 0) begin
                start = 1'b1; prog_we = 1'b0;
            end else if (trace[k].busy) begin
                start     = 1'($urandom_range(0, 1));
                prog_we   = 1'($urandom_range(0, 1));
                prog_addr = 5'($urandom);
                prog_data = 8'($urandom);
            end else begin
                start = 1'b0; prog_we = 1'b0;
            end
        end
        if (trace[trace.size()-1].halted) begin
            m_halt = 1'b1;
        end else begin
            #2;
            prog_we = 1'b0; start = 1'b0; rst_n = 1'b0;
            #1;
            check_zero("midrst");
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    initial begin
        #1;
        check_zero("reset");
        model_reset();
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // LDI 5 then HALT: halted with pc=1 seven busy cycles after start
        for (int i = 0; i < D; i++) m_mem[i] = 8'hE0;
        m_mem[0] = 8'hC5; m_mem[1] = 8'hE0;
        sync_mem();
        forced_res.delete(); forced_res.push_back(8'd5);
        run(10);
        chk("t1_trace_len", 32'(trace.size()), 32'd9);
        chk("t1_model_pc", 32'(trace[8].pc), 32'd1);
        chk("t1_halted", 32'(halted), 32'd1);
        chk("t1_pc", 32'(pc), 32'd1);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd7);

        // ADD R0,R0 (sees 5), LDI 3, ADD R0,R0 (sees 3), ADD R0,R0 (sees 6), HALT
        m_mem[0] = 8'h00; m_mem[1] = 8'hC3; m_mem[2] = 8'h00; m_mem[3] = 8'h00; m_mem[4] = 8'hE0;
        sync_mem();
        forced_res.delete();
        forced_res.push_back(8'd5); forced_res.push_back(8'd3);
        forced_res.push_back(8'd6); forced_res.push_back(8'h11);
        run(10);
        chk("t2_me_cycles", 32'(me_cnt), 32'd8);
        chk("t2_add1_regA", 32'(obs_a[0]), 32'd5);
        chk("t2_ldi_regB", 32'(obs_b[2]), 32'd0);
        chk("t2_add2_regA", 32'(obs_a[4]), 32'd3);
        chk("t2_add2_regB", 32'(obs_b[5]), 32'd3);
        chk("t2_add3_regA", 32'(obs_a[6]), 32'd6);
        chk("t2_add3_regB", 32'(obs_b[7]), 32'd6);

        // Reset during EXEC1 of an LDI, then confirm R0 reads back zero
        m_mem[0] = 8'hC3;
        sync_mem();
        run(1);
        m_mem[0] = 8'h00; m_mem[1] = 8'hE0;
        sync_mem();
        run(10);
        chk("t3_r0_after_reset", 32'(obs_a[0]), 32'd0);

        // Jump / opcode-5 behaviour
        for (int i = 0; i < D; i++) m_mem[i] = 8'h20;
        m_mem[0] = 8'hBF;
`ifdef FETCH_JMP_EN
        m_mem[31] = 8'hE0;
        sync_mem();
        run(10);
        chk("t4_jmp_me_cycles", 32'(me_cnt), 32'd0);
        chk("t4_jmp_pc", 32'(pc), 32'd31);
        chk("t4_jmp_halted", 32'(halted), 32'd1);
`else
        m_mem[1] = 8'hE0;
        sync_mem();
        run(10);
        chk("t4_op5_me_cycles", 32'(me_cnt), 32'd2);
        chk("t4_op5_pc", 32'(pc), 32'd1);
        chk("t4_op5_halted", 32'(halted), 32'd1);
`endif

        // All NOPs: pc wraps 31->0, main_enable 2 of every 5 cycles; ends with reset in EXEC1
        for (int i = 0; i < D; i++) m_mem[i] = 8'h20;
        sync_mem();
        run(34);
        chk("t5_trace_len", 32'(trace.size()), 32'd169);
        chk("t5_pc_wrap", 32'(saw_wrap), 32'd1);
        chk("t5_me_cycles", 32'(me_cnt), 32'd67);

        // Random programs with random start/prog_we noise while busy
        forced_res.delete();
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < D; i++) m_mem[i] = 8'($urandom);
            sync_mem();
            run($urandom_range(2, 40));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
